// File: rtl/codec_buffer_nd_wsource_if.sv
// Framed word stream carried into the write-side frame loader.
// master drives words; slave answers with ordy back-pressure.
interface codec_buffer_nd_wsource_if #(
  parameter int pDAT_W = 8
);
  logic              ival;
  logic              isop;
  logic              ieop;
  logic [pDAT_W-1:0] idat;
  logic              ordy;

  modport master (output ival, isop, ieop, idat, input ordy);
  modport slave  (input ival, isop, ieop, idat, output ordy);
endinterface

// File: rtl/codec_buffer_nd_wsource.sv
// Write-side frame loader in front of the multi-buffer bank logic.
// Takes a framed stream and turns it into RAM writes into the bank that
// was current at start of frame. It closes each frame with a one-cycle
// bank-full pulse and holds the source off while every bank is busy.
module codec_buffer_nd_wsource #(
  parameter int pBNUM_W = 1,
  parameter int pADDR_W = 8,
  parameter int pDAT_W  = 8
) (
  input  logic                       iwclk,
  input  logic                       iwreset,
  codec_buffer_nd_wsource_if.slave   src,
  input  logic [pBNUM_W-1:0]         iwused,
  input  logic                       iwfulla,
  output logic                       owrite,
  output logic [pBNUM_W+pADDR_W-1:0] owaddr,
  output logic [pDAT_W-1:0]          owdat,
  output logic                       ofull,
  output logic [pADDR_W-1:0]         olen,
  output logic                       oerr
);

  typedef enum logic [1:0] {IDLE, WRITE, CLOSE} state_t;

  // The counter carries one extra bit so the last legal word address can be
  // recognised without wrap-around ambiguity.
  localparam logic [pADDR_W:0]   CNT_ONE  = (pADDR_W+1)'(1);
  localparam logic [pADDR_W:0]   CNT_LAST = {1'b0, {pADDR_W{1'b1}}};
  localparam logic [pADDR_W-1:0] WORD_0   = '0;

  state_t                     state, state_nxt;
  logic [pBNUM_W-1:0]         bank, bank_nxt;
  logic [pADDR_W:0]           cnt, cnt_nxt;
  logic                       rdy_p0;
  logic                       write_nxt;
  logic [pBNUM_W+pADDR_W-1:0] addr_nxt;
  logic [pDAT_W-1:0]          dat_nxt;
  logic                       full_nxt;
  logic [pADDR_W-1:0]         len_nxt;
  logic                       err_nxt;

  // Ready is withheld for as long as reset is applied so the source never
  // sees a handshake from a block that is being cleared.
  assign src.ordy = rdy_p0 & ~iwreset;

  // State register plus latched bank and word counter.
  always_ff @(posedge iwclk or posedge iwreset) begin
    if (iwreset) begin
      state <= IDLE;
      bank  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      bank  <= bank_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state decode and next values of the registered write-port outputs.
  always_comb begin
    state_nxt = state;
    bank_nxt  = bank;
    cnt_nxt   = cnt;
    rdy_p0    = 1'b0;
    write_nxt = 1'b0;
    addr_nxt  = owaddr;
    dat_nxt   = owdat;
    full_nxt  = 1'b0;
    len_nxt   = olen;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        rdy_p0 = ~iwfulla;
        // Words arriving outside a frame without sop are silently dropped.
        if (rdy_p0 && src.ival && src.isop) begin
          bank_nxt  = iwused;
          cnt_nxt   = CNT_ONE;
          write_nxt = 1'b1;
          addr_nxt  = {iwused, WORD_0};
          dat_nxt   = src.idat;
          if (src.ieop) begin
            state_nxt = CLOSE;
            full_nxt  = 1'b1;
            len_nxt   = WORD_0;
          end else begin
            state_nxt = WRITE;
          end
        end
      end
      WRITE: begin
        // The write bank was free at sop, so iwfulla is not consulted here.
        rdy_p0 = 1'b1;
        if (src.ival) begin
          write_nxt = 1'b1;
          dat_nxt   = src.idat;
          if (src.isop) begin
            // Unexpected sop: drop the partial frame, restart in same bank.
            err_nxt  = 1'b1;
            cnt_nxt  = CNT_ONE;
            addr_nxt = {bank, WORD_0};
            if (src.ieop) begin
              state_nxt = CLOSE;
              full_nxt  = 1'b1;
              len_nxt   = WORD_0;
            end
          end else begin
            cnt_nxt  = cnt + CNT_ONE;
            addr_nxt = {bank, cnt[pADDR_W-1:0]};
            // Last address of the bank forces a close even without eop.
            if (src.ieop || cnt == CNT_LAST) begin
              state_nxt = CLOSE;
              full_nxt  = 1'b1;
              len_nxt   = cnt[pADDR_W-1:0];
              err_nxt   = ~src.ieop;
            end
          end
        end
      end
      CLOSE: begin
        // One dead cycle lets the bank logic register the closed bank
        // before iwfulla is trusted again.
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output register stage: write port, bank-full pulse and error pulse.
  always_ff @(posedge iwclk or posedge iwreset) begin
    if (iwreset) begin
      owrite <= 1'b0;
      owaddr <= '0;
      owdat  <= '0;
      ofull  <= 1'b0;
      olen   <= '0;
      oerr   <= 1'b0;
    end else begin
      owrite <= write_nxt;
      owaddr <= addr_nxt;
      owdat  <= dat_nxt;
      ofull  <= full_nxt;
      olen   <= len_nxt;
      oerr   <= err_nxt;
    end
  end

endmodule

// File: tb/tb_codec_buffer_nd_wsource.sv
// Bench for codec_buffer_nd_wsource: directed vector table, hand-written
// corner sequences and random traffic, all against a frame-level model.
module tb_codec_buffer_nd_wsource;

  localparam int BW = 1;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int MAXW = (1 << AW) - 1;

  logic          iwclk = 1'b0;
  logic          iwreset;
  logic [BW-1:0] iwused;
  logic          iwfulla;
  logic          owrite;
  logic [BW+AW-1:0] owaddr;
  logic [DW-1:0] owdat;
  logic          ofull;
  logic [AW-1:0] olen;
  logic          oerr;

  codec_buffer_nd_wsource_if #(.pDAT_W(DW)) src_if ();

  codec_buffer_nd_wsource #(.pBNUM_W(BW), .pADDR_W(AW), .pDAT_W(DW)) dut (
    .iwclk  (iwclk),
    .iwreset(iwreset),
    .src    (src_if),
    .iwused (iwused),
    .iwfulla(iwfulla),
    .owrite (owrite),
    .owaddr (owaddr),
    .owdat  (owdat),
    .ofull  (ofull),
    .olen   (olen),
    .oerr   (oerr)
  );

  always #5 iwclk = ~iwclk;

  int n_tests = 0;
  int n_fail  = 0;

  // Frame-level reference model.
  bit in_frame, closing;
  int m_bank, m_len;
  bit e_write, e_full, e_err;
  int e_addr, e_dat, e_len;

  // Observations from the most recent cycle.
  logic obs_rdy, obs_write, obs_full, obs_err;
  logic [BW+AW-1:0] obs_addr;
  logic [DW-1:0] obs_dat;
  logic [AW-1:0] obs_len;
  int wr_cnt, full_cnt, err_cnt;

  typedef struct {
    logic v, s, e;
    logic [DW-1:0] d;
    logic [BW-1:0] u;
    logic f;
    logic x_rdy, x_write, x_full;
    logic [BW+AW-1:0] x_addr;
    logic [AW-1:0] x_len;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    in_frame = 0; closing = 0; m_bank = 0; m_len = 0;
    e_write = 0; e_full = 0; e_err = 0; e_addr = 0; e_dat = 0; e_len = 0;
  endtask

  // Called at a negedge: apply one word slot, check ready, then the
  // registered outputs after the following posedge.
  task automatic drive(input logic v, input logic s, input logic e,
                       input logic [DW-1:0] d, input logic [BW-1:0] u, input logic f);
    bit rdy, acc;
    src_if.ival = v; src_if.isop = s; src_if.ieop = e; src_if.idat = d;
    iwused = u; iwfulla = f;
    #1;
    rdy = closing ? 1'b0 : (in_frame ? 1'b1 : !f);
    obs_rdy = src_if.ordy;
    check("ordy", {31'd0, obs_rdy}, {31'd0, rdy});
    acc = v && rdy;
    e_write = 0; e_full = 0; e_err = 0;
    if (closing) begin
      closing = 0;
    end else if (acc) begin
      if (s) begin
        if (in_frame) e_err = 1;
        else m_bank = int'(u);
        in_frame = 1;
        m_len = 0;
      end
      if (in_frame) begin
        e_write = 1;
        e_addr = m_bank * (MAXW + 1) + m_len;
        e_dat = int'(d);
        if (e || m_len == MAXW) begin
          e_full = 1;
          e_len = m_len;
          if (!e) e_err = 1;
          in_frame = 0;
          closing = 1;
        end
        m_len++;
      end
    end
    @(posedge iwclk);
    #1;
    obs_write = owrite; obs_addr = owaddr; obs_dat = owdat;
    obs_full = ofull; obs_len = olen; obs_err = oerr;
    check("owrite", {31'd0, owrite}, {31'd0, e_write});
    if (e_write) begin
      check("owaddr", 32'(owaddr), e_addr);
      check("owdat", 32'(owdat), e_dat);
    end
    check("ofull", {31'd0, ofull}, {31'd0, e_full});
    if (e_full) check("olen", 32'(olen), e_len);
    check("oerr", {31'd0, oerr}, {31'd0, e_err});
    if (owrite) wr_cnt++;
    if (ofull) full_cnt++;
    if (oerr) err_cnt++;
    @(negedge iwclk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ordy"}, {31'd0, src_if.ordy}, 0);
    check({tag, "_owrite"}, {31'd0, owrite}, 0);
    check({tag, "_owaddr"}, 32'(owaddr), 0);
    check({tag, "_owdat"}, 32'(owdat), 0);
    check({tag, "_ofull"}, {31'd0, ofull}, 0);
    check({tag, "_olen"}, 32'(olen), 0);
    check({tag, "_oerr"}, {31'd0, oerr}, 0);
  endtask

  task automatic clear_tally();
    wr_cnt = 0; full_cnt = 0; err_cnt = 0;
  endtask

  initial begin
    // v s e  d      u f | rdy wr full addr  len
    tbl[0] = '{1,1,0,8'hA0,1'b0,0, 1,1,0,9'h000,8'd0};
    tbl[1] = '{1,0,0,8'hA1,1'b0,0, 1,1,0,9'h001,8'd0};
    tbl[2] = '{1,0,0,8'hA2,1'b0,0, 1,1,0,9'h002,8'd0};
    tbl[3] = '{1,0,1,8'hA3,1'b0,0, 1,1,1,9'h003,8'd3};
    tbl[4] = '{0,0,0,8'h00,1'b0,0, 0,0,0,9'h000,8'd0};
    tbl[5] = '{1,1,1,8'hB0,1'b1,0, 1,1,1,9'h100,8'd0};
    tbl[6] = '{0,0,0,8'h00,1'b1,0, 0,0,0,9'h000,8'd0};
    tbl[7] = '{0,0,0,8'h00,1'b1,0, 1,0,0,9'h000,8'd0};

    src_if.ival = 0; src_if.isop = 0; src_if.ieop = 0; src_if.idat = '0;
    iwused = '0; iwfulla = 1'b0;
    iwreset = 1'b1;
    model_reset();
    clear_tally();
    @(negedge iwclk);
    #1;
    check_zero("rst");
    @(negedge iwclk);
    iwreset = 1'b0;

    // Directed vectors: 4-word frame then single-word frame.
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].v, tbl[i].s, tbl[i].e, tbl[i].d, tbl[i].u, tbl[i].f);
      check("tbl_rdy", {31'd0, obs_rdy}, {31'd0, tbl[i].x_rdy});
      check("tbl_write", {31'd0, obs_write}, {31'd0, tbl[i].x_write});
      if (tbl[i].x_write) begin
        check("tbl_addr", 32'(obs_addr), 32'(tbl[i].x_addr));
        check("tbl_dat", 32'(obs_dat), 32'(tbl[i].d));
      end
      check("tbl_full", {31'd0, obs_full}, {31'd0, tbl[i].x_full});
      if (tbl[i].x_full) check("tbl_len", 32'(obs_len), 32'(tbl[i].x_len));
    end

    // All banks busy: sop held, nothing accepted until iwfulla drops.
    clear_tally();
    for (int i = 0; i < 3; i++) drive(1, 1, 0, 8'h55, 1'b1, 1);
    check("stall_writes", wr_cnt, 0);
    drive(1, 1, 0, 8'h55, 1'b1, 0);
    check("stall_addr", 32'(obs_addr), 32'h100);
    drive(1, 0, 1, 8'h56, 1'b0, 1);
    drive(0, 0, 0, 8'h00, 1'b0, 0);

    // 300 words without eop: forced close at word 256, rest dropped.
    clear_tally();
    for (int i = 0; i < 300; i++) drive(1, i == 0, 0, 8'(i), 1'b0, 0);
    check("ovf_writes", wr_cnt, 256);
    check("ovf_fulls", full_cnt, 1);
    check("ovf_errs", err_cnt, 1);

    // sop inside a frame: restart at word 0, then close with new length.
    clear_tally();
    for (int i = 0; i < 6; i++) drive(1, i == 0 || i == 3, i == 5, 8'h30 + 8'(i), 1'b1, 0);
    check("resop_len", 32'(obs_len), 2);
    check("resop_fulls", full_cnt, 1);
    check("resop_errs", err_cnt, 1);
    drive(0, 0, 0, 8'h00, 1'b0, 0);

    // Reset in the middle of a frame.
    clear_tally();
    for (int i = 0; i < 5; i++) drive(1, i == 0, 0, 8'h70 + 8'(i), 1'b0, 0);
    iwreset = 1'b1;
    #1;
    check_zero("mid_rst");
    model_reset();
    @(posedge iwclk);
    @(negedge iwclk);
    iwreset = 1'b0;
    drive(1, 0, 1, 8'h7F, 1'b0, 1);
    drive(1, 0, 1, 8'h7F, 1'b0, 0);
    check("mid_rst_fulls", full_cnt, 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0,
            $urandom_range(0, 19) < 3, 8'($urandom), 1'($urandom),
            $urandom_range(0, 4) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
